// File: rtl/neuron_compute_engine_pkg.sv
// -----------------------------------------------------------------------------
// neuron_compute_engine_pkg
// Shared definitions for the dense-layer compute engine:
//   - default width/geometry parameters
//   - accumulator width derivation
//   - one-hot FSM state encoding (also used by the control FSM that muxes the
//     RAM ports between capture, compute and streaming phases)
// No ports (package).
// -----------------------------------------------------------------------------
package neuron_compute_engine_pkg;

    localparam int DEF_BIT_WIDTH    = 8;
    localparam int DEF_NR_DEPTH     = 64;
    localparam int DEF_DEPTH_BITS   = 6;
    localparam int DEF_NR_FEATURE   = 8;
    localparam int DEF_FEATURE_BITS = 3;
    localparam int DEF_NR_NEURON    = 3;
    localparam int DEF_NEURON_BITS  = 2;
    localparam int DEF_FRAC_BITS    = 8;

    // Signed x unsigned product needs 2*W+1 bits; summing up to 2^FEATURE_BITS
    // terms adds FEATURE_BITS more, so the accumulator can never overflow.
    function automatic int acc_bits(input int bit_width, input int feature_bits);
        return 2 * bit_width + feature_bits + 1;
    endfunction

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_READ  = 6'b000010,
        ST_WAIT  = 6'b000100,
        ST_MAC   = 6'b001000,
        ST_WRITE = 6'b010000,
        ST_DONE  = 6'b100000
    } state_e;

endpackage

// File: rtl/neuron_compute_engine_mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Datapath of the compute engine: holds the captured data/weight rows,
// accumulates the biased dot product one feature per cycle and presents the
// ReLU-clamped, saturated 8-bit result. No control state lives here.
// Ports:
//   clk_i        clock (rising edge)
//   load_i       capture both rows and clear the accumulator
//   clear_i      clear the accumulator only
//   mac_en_i     accumulate the term selected by feat_i
//   feat_i       feature index (0 = bias slot)
//   data_row_i   unsigned data row, feature f at [f*BIT_WIDTH +: BIT_WIDTH]
//   weight_row_i signed weight row, same packing
//   result_o     clamped result of the current accumulator
// -----------------------------------------------------------------------------
module mac_unit
    import neuron_compute_engine_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int NR_FEATURE   = DEF_NR_FEATURE,
    parameter int FEATURE_BITS = DEF_FEATURE_BITS,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int ACC_BITS     = acc_bits(DEF_BIT_WIDTH, DEF_FEATURE_BITS)
) (
    input  logic                             clk_i,
    input  logic                             load_i,
    input  logic                             clear_i,
    input  logic                             mac_en_i,
    input  logic [FEATURE_BITS-1:0]          feat_i,
    input  logic [NR_FEATURE*BIT_WIDTH-1:0]  data_row_i,
    input  logic [NR_FEATURE*BIT_WIDTH-1:0]  weight_row_i,
    output logic [BIT_WIDTH-1:0]             result_o
);

    localparam int ROW_W   = NR_FEATURE * BIT_WIDTH;
    localparam int PROD_W  = 2 * BIT_WIDTH + 1;
    localparam logic signed [ACC_BITS-1:0] RES_MAX = ACC_BITS'((1 << BIT_WIDTH) - 1);

    logic [ROW_W-1:0]               data_row_q;
    logic [ROW_W-1:0]               weight_row_q;
    logic signed [ACC_BITS-1:0]     acc_q;
    logic signed [ACC_BITS-1:0]     acc_d;

    logic signed [BIT_WIDTH-1:0]    w_sel;
    logic        [BIT_WIDTH-1:0]    x_sel;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_BITS-1:0]     bias_term;
    logic signed [ACC_BITS-1:0]     prod_term;

    // r = acc >>> FRAC_BITS, then ReLU at 0 and saturate at 2^BIT_WIDTH-1.
    function automatic logic [BIT_WIDTH-1:0] relu_sat(input logic signed [ACC_BITS-1:0] acc);
        logic signed [ACC_BITS-1:0] r;
        r = acc >>> FRAC_BITS;
        if (r < 0) begin
            return '0;
        end else if (r > RES_MAX) begin
            return '1;
        end else begin
            return r[BIT_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        w_sel     = weight_row_q[int'(feat_i) * BIT_WIDTH +: BIT_WIDTH];
        x_sel     = data_row_q[int'(feat_i) * BIT_WIDTH +: BIT_WIDTH];
        // Zero-extend the data word so the multiply stays signed.
        prod      = w_sel * $signed({1'b0, x_sel});
        bias_term = {{(ACC_BITS - BIT_WIDTH){w_sel[BIT_WIDTH-1]}}, w_sel};
        bias_term = bias_term <<< FRAC_BITS;
        prod_term = {{(ACC_BITS - PROD_W){prod[PROD_W-1]}}, prod};

        acc_d = acc_q;
        if (load_i || clear_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            // Slot 0 of the data row is the implicit constant 1.0.
            acc_d = acc_q + ((feat_i == '0) ? bias_term : prod_term);
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_row_q   <= data_row_i;
            weight_row_q <= weight_row_i;
        end
        acc_q <= acc_d;
    end

    assign result_o = relu_sat(acc_q);

endmodule

// File: rtl/neuron_compute_engine.sv
// -----------------------------------------------------------------------------
// neuron_compute_engine
// Fixed-point dense-layer engine. On Compute_enable it walks every dataset row
// d of the Data RAM and every neuron n of the Weight RAM, computes the biased
// dot product, applies ReLU/saturation and writes the byte into the Result RAM
// at (d, n). Compute_Done is raised once all writes have been issued.
// Ports:
//   ACLK, ARESETN                  clock, synchronous active-low reset
//   Compute_enable / Compute_Done  level request / completion flag
//   Data_read_*                    Data RAM read strobe, row address, row in
//   Weight_read_*                  Weight RAM read strobe, neuron address, row in
//   RES_write_*                    Result RAM write strobe, (row, neuron), data
// -----------------------------------------------------------------------------
module neuron_compute_engine
    import neuron_compute_engine_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int NR_DEPTH     = DEF_NR_DEPTH,
    parameter int DEPTH_BITS   = DEF_DEPTH_BITS,
    parameter int NR_FEATURE   = DEF_NR_FEATURE,
    parameter int FEATURE_BITS = DEF_FEATURE_BITS,
    parameter int NR_NEURON    = DEF_NR_NEURON,
    parameter int NEURON_BITS  = DEF_NEURON_BITS,
    parameter int FRAC_BITS    = DEF_FRAC_BITS
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            Compute_enable,
    output logic                            Compute_Done,
    output logic                            Data_read_en,
    output logic [DEPTH_BITS-1:0]           Data_read_address_depth,
    input  logic [NR_FEATURE*BIT_WIDTH-1:0] Data_read_row,
    output logic                            Weight_read_en,
    output logic [NEURON_BITS-1:0]          Weight_read_address_depth,
    input  logic [NR_FEATURE*BIT_WIDTH-1:0] Weight_read_row,
    output logic                            RES_write_en,
    output logic [DEPTH_BITS-1:0]           RES_write_address_depth,
    output logic [FEATURE_BITS-1:0]         RES_write_address_width,
    output logic [BIT_WIDTH-1:0]            RES_write_data_in
);

    localparam int ACC_BITS = acc_bits(BIT_WIDTH, FEATURE_BITS);
    localparam logic [DEPTH_BITS-1:0]   D_LAST = DEPTH_BITS'(NR_DEPTH - 1);
    localparam logic [NEURON_BITS-1:0]  N_LAST = NEURON_BITS'(NR_NEURON - 1);
    localparam logic [FEATURE_BITS-1:0] F_LAST = FEATURE_BITS'(NR_FEATURE - 1);

    state_e                  state_q, state_d;
    logic [DEPTH_BITS-1:0]   d_q, d_d;
    logic [NEURON_BITS-1:0]  n_q, n_d;
    logic [FEATURE_BITS-1:0] f_q, f_d;

    logic rd_en, wr_en, done, load, clear, mac_en;
    logic [BIT_WIDTH-1:0] result;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            n_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            n_q     <= n_d;
            f_q     <= f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        n_d     = n_q;
        f_d     = f_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        mac_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                d_d   = '0;
                n_d   = '0;
                f_d   = '0;
                clear = 1'b1;
                if (Compute_enable) state_d = ST_READ;
            end
            ST_READ: begin
                rd_en   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // RAM rows are valid only in this cycle; latch them now.
                load    = 1'b1;
                f_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                f_d    = f_q + 1'b1;
                if (f_q == F_LAST) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (n_q == N_LAST) begin
                    n_d = '0;
                    d_d = d_q + 1'b1;
                end else begin
                    n_d = n_q + 1'b1;
                end
                state_d = ((d_q == D_LAST) && (n_q == N_LAST)) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!Compute_enable) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping the request anywhere in the walk abandons it; the strobe
        // of the current cycle (e.g. a WRITE) is still issued.
        if (!Compute_enable && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
            d_d     = '0;
            n_d     = '0;
        end
    end

    mac_unit #(
        .BIT_WIDTH    (BIT_WIDTH),
        .NR_FEATURE   (NR_FEATURE),
        .FEATURE_BITS (FEATURE_BITS),
        .FRAC_BITS    (FRAC_BITS),
        .ACC_BITS     (ACC_BITS)
    ) u_mac (
        .clk_i        (ACLK),
        .load_i       (load),
        .clear_i      (clear),
        .mac_en_i     (mac_en),
        .feat_i       (f_q),
        .data_row_i   (Data_read_row),
        .weight_row_i (Weight_read_row),
        .result_o     (result)
    );

    // Addresses and data are forced to zero outside their strobes so idle
    // ports are quiet.
    assign Compute_Done              = done;
    assign Data_read_en              = rd_en;
    assign Weight_read_en            = rd_en;
    assign Data_read_address_depth   = rd_en ? d_q : '0;
    assign Weight_read_address_depth = rd_en ? n_q : '0;
    assign RES_write_en              = wr_en;
    assign RES_write_address_depth   = wr_en ? d_q : '0;
    assign RES_write_address_width   = wr_en ? FEATURE_BITS'(n_q) : '0;
    assign RES_write_data_in         = wr_en ? result : '0;

endmodule

// File: tb/tb_neuron_compute_engine.sv
module tb_neuron_compute_engine;

    localparam int BW    = 8;
    localparam int ND    = 64;
    localparam int DB    = 6;
    localparam int NF    = 8;
    localparam int FB    = 3;
    localparam int NN    = 3;
    localparam int NB    = 2;
    localparam int TOTAL = ND * NN;
    localparam int RUN   = ND * NN * (NF + 3);

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic Compute_enable = 1'b0;
    logic Compute_Done;
    logic Data_read_en, Weight_read_en, RES_write_en;
    logic [DB-1:0] Data_read_address_depth, RES_write_address_depth;
    logic [NB-1:0] Weight_read_address_depth;
    logic [FB-1:0] RES_write_address_width;
    logic [BW-1:0] RES_write_data_in;
    logic [NF*BW-1:0] Data_read_row, Weight_read_row;

    neuron_compute_engine dut (
        .ACLK                      (ACLK),
        .ARESETN                   (ARESETN),
        .Compute_enable            (Compute_enable),
        .Compute_Done              (Compute_Done),
        .Data_read_en              (Data_read_en),
        .Data_read_address_depth   (Data_read_address_depth),
        .Data_read_row             (Data_read_row),
        .Weight_read_en            (Weight_read_en),
        .Weight_read_address_depth (Weight_read_address_depth),
        .Weight_read_row           (Weight_read_row),
        .RES_write_en              (RES_write_en),
        .RES_write_address_depth   (RES_write_address_depth),
        .RES_write_address_width   (RES_write_address_width),
        .RES_write_data_in         (RES_write_data_in)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int dmem [ND][NF];
    int wmem [NN][NF];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int c; int d; int n; int v;} wr_t;
    wr_t wq[$];
    int first_rd = -1;
    int last_rd  = -1;
    int rd_cnt   = 0;
    int overlap  = 0;
    int done_cnt = 0;

    // RAMs with one-cycle read latency; outputs are garbage when not read.
    always @(posedge ACLK) begin
        logic [NF*BW-1:0] rd, rw;
        rd = {$urandom, $urandom};
        rw = {$urandom, $urandom};
        if (Data_read_en)
            for (int f = 0; f < NF; f++) rd[f*BW +: BW] = BW'(dmem[Data_read_address_depth][f]);
        if (Weight_read_en)
            for (int f = 0; f < NF; f++) rw[f*BW +: BW] = BW'(wmem[Weight_read_address_depth][f]);
        Data_read_row   <= rd;
        Weight_read_row <= rw;
    end

    always @(negedge ACLK) begin
        if (RES_write_en)
            wq.push_back('{cyc, int'(RES_write_address_depth), int'(RES_write_address_width),
                           int'(RES_write_data_in)});
        if (Data_read_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
        end
        if (RES_write_en && (Data_read_en || Weight_read_en)) overlap++;
        if (Compute_Done) done_cnt++;
    end

    // Reference: biased dot product in plain integers, ReLU, floor by 2^8, clamp.
    function automatic int model(input int d, input int n);
        int acc;
        acc = wmem[n][0] * 256;
        for (int f = 1; f < NF; f++) acc += wmem[n][f] * dmem[d][f];
        if (acc < 0) return 0;
        if (acc / 256 > 255) return 255;
        return acc / 256;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic fill(input int p);
        for (int d = 0; d < ND; d++)
            for (int f = 0; f < NF; f++)
                case (p)
                    0: dmem[d][f] = 0;
                    1: dmem[d][f] = (f == 0) ? int'($urandom_range(255)) : 255;
                    3: dmem[d][f] = 255;
                    default: dmem[d][f] = int'($urandom_range(255));
                endcase
        for (int n = 0; n < NN; n++)
            for (int f = 0; f < NF; f++)
                case (p)
                    0: wmem[n][f] = (f == 0) ? 5 : 0;
                    1: wmem[n][f] = (f == 0) ? 0 : 1;
                    2: wmem[n][f] = (f == 0) ? -128 : 0;
                    3: wmem[n][f] = 127;
                    default: wmem[n][f] = int'($urandom_range(255)) - 128;
                endcase
    endtask

    // Called at a drive point; returns the edge index E0 that samples enable.
    task automatic start_run(output int e0);
        wq.delete();
        first_rd = -1;
        last_rd  = -1;
        done_cnt = 0;
        Compute_enable = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < RUN + 400; i++) begin
            @(negedge ACLK);
            if (Compute_Done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 2) ARESETN = 1'b1;
            @(negedge ACLK);
            n_checks++;
            if ({Compute_Done, Data_read_en, Weight_read_en, RES_write_en, Data_read_address_depth,
                 Weight_read_address_depth, RES_write_address_depth, RES_write_address_width,
                 RES_write_data_in} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d: got done=%b rd=%b wr=%b, required all zero",
                         k, Compute_Done, Data_read_en, RES_write_en);
            end
        end
    endtask

    task automatic test_full_runs();
        int e0, dcyc, lim;
        for (int p = 0; p < 5; p++) begin
            fill(p);
            tick();
            start_run(e0);
            wait_done(dcyc);
            n_checks++;
            if (dcyc !== e0 + RUN) begin
                n_fail++;
                $display("FAIL done_time p=%0d: got cycle %0d, required %0d", p, dcyc - e0, RUN);
            end
            n_checks++;
            if (first_rd !== e0) begin
                n_fail++;
                $display("FAIL first_read p=%0d: got cycle %0d, required %0d", p, first_rd - e0, 0);
            end
            n_checks++;
            if (wq.size() !== TOTAL) begin
                n_fail++;
                $display("FAIL write_count p=%0d: got %0d, required %0d", p, wq.size(), TOTAL);
            end
            n_checks++;
            if (wq.size() == 0 || wq[0].c !== e0 + NF + 2) begin
                n_fail++;
                $display("FAIL first_write p=%0d: got cycle %0d, required %0d", p,
                         (wq.size() == 0) ? -1 : wq[0].c - e0, NF + 2);
            end
            lim = (wq.size() < TOTAL) ? wq.size() : TOTAL;
            for (int i = 0; i < lim; i++) begin
                n_checks++;
                if (wq[i].d !== i / NN || wq[i].n !== i % NN) begin
                    n_fail++;
                    $display("FAIL write_addr p=%0d i=%0d: got (%0d,%0d), required (%0d,%0d)",
                             p, i, wq[i].d, wq[i].n, i / NN, i % NN);
                end
                n_checks++;
                if (wq[i].v !== model(i / NN, i % NN)) begin
                    n_fail++;
                    $display("FAIL write_data p=%0d i=%0d: got %0d, required %0d",
                             p, i, wq[i].v, model(i / NN, i % NN));
                end
            end
            Compute_enable = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic test_done_hold();
        int e0, dcyc, wsz, rsz;
        fill(4);
        tick();
        start_run(e0);
        wait_done(dcyc);
        wsz = wq.size();
        rsz = rd_cnt;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            n_checks++;
            if (Compute_Done !== 1'b1) begin
                n_fail++;
                $display("FAIL done_hold k=%0d: got %b, required 1", k, Compute_Done);
            end
        end
        tick();
        n_checks++;
        if (wq.size() !== wsz || rd_cnt !== rsz) begin
            n_fail++;
            $display("FAIL hold_strobes: got %0d extra writes %0d extra reads, required 0 and 0",
                     wq.size() - wsz, rd_cnt - rsz);
        end
        Compute_enable = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (Compute_Done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_before_fall: got %b, required 1", Compute_Done);
        end
        @(negedge ACLK);
        n_checks++;
        if (Compute_Done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_fall: got %b, required 0", Compute_Done);
        end
        tick();
        start_run(e0);
        repeat (4) tick();
        n_checks++;
        if (first_rd !== e0) begin
            n_fail++;
            $display("FAIL restart_from_idle: got first read at %0d, required %0d", first_rd - e0, 0);
        end
        Compute_enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_abort();
        int e0, e1, late;
        fill(5);
        tick();
        start_run(e0);
        while (cyc < e0 + 500) tick();
        Compute_enable = 1'b0;
        repeat (60) tick();
        late = 0;
        foreach (wq[i]) if (wq[i].c > e0 + 501) late++;
        if (last_rd > e0 + 501) late++;
        n_checks++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL abort_late_strobes: got %0d, required 0", late);
        end
        n_checks++;
        if (wq.size() !== 45) begin
            n_fail++;
            $display("FAIL abort_write_count: got %0d, required %0d", wq.size(), 45);
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_done: got %0d done cycles, required 0", done_cnt);
        end
        start_run(e1);
        repeat (14) tick();
        n_checks++;
        if (wq.size() == 0 || wq[0].d !== 0 || wq[0].n !== 0 || wq[0].c !== e1 + NF + 2) begin
            n_fail++;
            $display("FAIL abort_restart: got size %0d first (%0d,%0d) at %0d, required (0,0) at %0d",
                     wq.size(), (wq.size() > 0) ? wq[0].d : -1, (wq.size() > 0) ? wq[0].n : -1,
                     (wq.size() > 0) ? wq[0].c - e1 : -1, NF + 2);
        end
        n_checks++;
        if (wq.size() == 0 || wq[0].v !== model(0, 0)) begin
            n_fail++;
            $display("FAIL abort_restart_data: got %0d, required %0d",
                     (wq.size() > 0) ? wq[0].v : -1, model(0, 0));
        end
        Compute_enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int e0, dcyc;
        fill(6);
        tick();
        start_run(e0);
        while (cyc < e0 + 300) tick();
        ARESETN = 1'b0;
        Compute_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) ARESETN = 1'b1;
            @(negedge ACLK);
            n_checks++;
            if ({Compute_Done, Data_read_en, Weight_read_en, RES_write_en, Data_read_address_depth,
                 Weight_read_address_depth, RES_write_address_depth, RES_write_address_width,
                 RES_write_data_in} !== '0) begin
                n_fail++;
                $display("FAIL midreset_outputs k=%0d: got done=%b rd=%b wr=%b, required all zero",
                         k, Compute_Done, Data_read_en, RES_write_en);
            end
        end
        tick();
        start_run(e0);
        wait_done(dcyc);
        n_checks++;
        if (dcyc !== e0 + RUN) begin
            n_fail++;
            $display("FAIL postreset_done: got cycle %0d, required %0d", dcyc - e0, RUN);
        end
        n_checks++;
        if (wq.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL postreset_count: got %0d, required %0d", wq.size(), TOTAL);
        end
        n_checks++;
        if (wq.size() == 0 || wq[0].d !== 0 || wq[0].n !== 0 || wq[0].v !== model(0, 0)) begin
            n_fail++;
            $display("FAIL postreset_first: got value %0d, required %0d at (0,0)",
                     (wq.size() > 0) ? wq[0].v : -1, model(0, 0));
        end
        Compute_enable = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_full_runs();
        test_done_hold();
        test_abort();
        test_reset_mid();
        n_checks++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL rd_wr_overlap: got %0d cycles, required 0", overlap);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
